com_sw_to_fw_seq: RTL and testbench
===================================

// Module: com_sw_to_fw_seq
// PURPOSE
//  Registered, parametrised SW-to-FW command bridge; successor of the combinational decoder.
//  Latches one 32-bit SW command {dev_id[31:28], op_code[27:24], body[23:0]} on a write strobe.
//  Routes the command to one of NUM_FW firmware blocks and waits for that block's done pulse.
//  Captures its data/status words for SW; adds busy/done/error flags, timeout and a command counter.
// PARAMETERS
//  NUM_FW          4     number of attached FW blocks, 1..15
//  DEV_ID_ONEHOT   1     1: dev_id is one-hot (legal only if NUM_FW<=4); 0: dev_id is binary 1..NUM_FW
//  TIMEOUT_CYCLES  1024  max cycles in WAIT before abort, >=2; counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  fw_axi_clk        in   1            single clock
//  fw_rst_n          in   1            asynchronous, active-low reset
//  sw_write_strobe   in   1            1-cycle pulse: sw_write32_0 holds a new command
//  sw_write32_0      in   32           SW command word
//  sw_read32_0       out  32           captured read data of the last completed command
//  sw_read32_1       out  32           captured FW status of the last completed command
//  sw_read32_2       out  32           bridge status: [31]busy [30]done [29]err_dev [28]err_op [27]err_timeout [26]err_overrun [15:0]cmd_count
//  fw_dev_id_enable  out  NUM_FW       one-hot select, held for the whole transaction
//  fw_op_pulse       out  12           one-hot op strobe, bit n = op code n, 1 cycle wide, bit0 never set
//  sw_write24_0      out  24           body bytes latched at command accept, held until next accept
//  fw_op_done        in   NUM_FW       per-FW 1-cycle completion pulse
//  fw_read_data32    in   NUM_FW x 32  per-FW read data
//  fw_read_status32  in   NUM_FW x 32  per-FW status
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, counters and flags 0.
//  Decode:
//   - Onehot mode: dev 1,2,4,8 -> index 0..3.
//   - Binary mode: dev k -> index k-1.
//   - Any other value is an invalid dev.
//   - Legal op codes are 0x0..0xB; 0xC..0xF are invalid op.
//  FSM IDLE/ISSUE/WAIT/CAPTURE:
//   - IDLE + strobe: latch word and body; sw_write24_0 updates the next cycle.
//   - dev=0 with op=0xA: clear err_* and done; stay IDLE; counter unchanged.
//   - Other invalid dev or op: set err_dev / err_op and done; stay IDLE; no FW strobe.
//   - op=0x0 (NOOP) with valid dev: set done, increment cmd_count, no FW strobe.
//   - Otherwise: clear done, set busy, go to ISSUE.
//   - ISSUE: drive fw_dev_id_enable[sel] and fw_op_pulse[op] for one cycle -> WAIT.
//     First pulse is 2 cycles after the strobe.
//   - WAIT: fw_dev_id_enable held.
//     - fw_op_done[sel] -> CAPTURE.
//     - done pulses from non-selected FW are ignored.
//     - Done arriving in the same cycle as the timeout limit: done wins.
//     - Timeout counter reaches TIMEOUT_CYCLES: set err_timeout, load sw_read32_0/1 with 0, -> IDLE.
//   - CAPTURE: sample fw_read_data32[sel] and fw_read_status32[sel] into sw_read32_0/1.
//     Set done, clear busy, increment cmd_count (wraps 0xFFFF->0), drop fw_dev_id_enable -> IDLE.
//  Strobe while not IDLE: command dropped, err_overrun set (sticky).
//   - A strobe in the CAPTURE cycle is also dropped.
//  Error flags are sticky; only the clear command clears them.
//  Timeout also increments cmd_count.
//  Reset mid-transaction returns to IDLE at once; outputs go to 0 asynchronously.
// TESTING
//  1 NUM_FW=4 onehot: strobe 0x2300_00AB, FW1 done 5 cyc later with data 0x1234_5678
//    -> fw_op_pulse[3] 1 cycle, enable=0x2.
//    -> read0=0x1234_5678, done=1, cmd_count=1, sw_write24_0=0x0000AB.
//  2 Strobe 0x3200_0000 (onehot invalid dev)
//    -> err_dev=1, no fw_op_pulse.
//    -> then strobe 0x0A00_0000 -> err_dev=0.
//  3 Strobe 0x1B00_0001, no done from FW0 -> err_timeout=1 exactly TIMEOUT_CYCLES after WAIT entry; read0=0.
//  4 During WAIT: strobe 0x2500_0000 and FW2 done pulse
//    -> err_overrun=1, FW2 done ignored, transaction continues with FW0.
//  5 DEV_ID_ONEHOT=0 NUM_FW=8: strobe 0x7800_0000 -> enable=0x40, fw_op_pulse[8];
//    strobe 0x9800_0000 -> err_dev.
//  6 fw_rst_n low in WAIT -> all outputs 0 immediately; next command after release behaves as in 1.

Source files
------------

// File: rtl/com_sw_to_fw_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : com_sw_to_fw_seq
//  Description : Registered SW-to-FW command bridge. Accepts one SW command,
//                strobes the addressed FW block, waits for its done pulse
//                and captures its data/status words, with bridge status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module com_sw_to_fw_seq #(
    parameter int NUM_FW         = 4,
    parameter int DEV_ID_ONEHOT  = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   fw_axi_clk,
    input  logic                   fw_rst_n,
    input  logic                   sw_write_strobe,
    input  logic [31:0]            sw_write32_0,
    output logic [31:0]            sw_read32_0,
    output logic [31:0]            sw_read32_1,
    output logic [31:0]            sw_read32_2,
    output logic [NUM_FW-1:0]      fw_dev_id_enable,
    output logic [11:0]            fw_op_pulse,
    output logic [23:0]            sw_write24_0,
    input  logic [NUM_FW-1:0]      fw_op_done,
    input  logic [NUM_FW*32-1:0]   fw_read_data32,
    input  logic [NUM_FW*32-1:0]   fw_read_status32
);

    localparam int         c_CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_WAIT    = 2'd2;
    localparam logic [1:0] c_ST_CAPTURE = 2'd3;

    logic [1:0]         r_state;
    logic [3:0]         r_sel;
    logic [3:0]         r_op;
    logic [23:0]        r_body;
    logic [31:0]        r_rd0;
    logic [31:0]        r_rd1;
    logic [NUM_FW-1:0]  r_en;
    logic [11:0]        r_pulse;
    logic               r_busy;
    logic               r_done;
    logic               r_err_dev;
    logic               r_err_op;
    logic               r_err_to;
    logic               r_err_ovr;
    logic [15:0]        r_count;
    logic [c_CNT_W-1:0] r_cnt;

    logic [3:0]         w_dev;
    logic [3:0]         w_op;
    logic               w_dev_ok;
    logic [3:0]         w_dev_idx;
    logic               w_op_ok;
    logic               w_sel_done;
    logic [31:0]        w_sel_data;
    logic [31:0]        w_sel_stat;
    logic [NUM_FW-1:0]  w_sel_onehot;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_timeout;

    assign w_dev      = sw_write32_0[31:28];
    assign w_op       = sw_write32_0[27:24];
    assign w_op_ok    = (w_op <= 4'hB);
    assign w_cnt_next = r_cnt + c_CNT_W'(1);
    assign w_timeout  = (w_cnt_next == c_CNT_W'(TIMEOUT_CYCLES));

    // dev_id decode of the incoming word; one-hot mode only maps the low four FW slots
    always_comb begin
        w_dev_ok  = 1'b0;
        w_dev_idx = 4'd0;
        for (int i = 0; i < NUM_FW; i++) begin
            if (DEV_ID_ONEHOT != 0) begin
                if ((i < 4) && (w_dev == 4'(1 << i))) begin
                    w_dev_ok  = 1'b1;
                    w_dev_idx = 4'(i);
                end
            end else if (w_dev == 4'(i + 1)) begin
                w_dev_ok  = 1'b1;
                w_dev_idx = 4'(i);
            end
        end
    end

    always_comb begin
        w_sel_done   = 1'b0;
        w_sel_data   = 32'd0;
        w_sel_stat   = 32'd0;
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_FW; i++) begin
            if (r_sel == 4'(i)) begin
                w_sel_done      = fw_op_done[i];
                w_sel_data      = fw_read_data32[i*32 +: 32];
                w_sel_stat      = fw_read_status32[i*32 +: 32];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            r_state   <= c_ST_IDLE;
            r_sel     <= 4'd0;
            r_op      <= 4'd0;
            r_body    <= 24'd0;
            r_rd0     <= 32'd0;
            r_rd1     <= 32'd0;
            r_en      <= '0;
            r_pulse   <= 12'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err_dev <= 1'b0;
            r_err_op  <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_ovr <= 1'b0;
            r_count   <= 16'd0;
            r_cnt     <= '0;
        end else begin
            r_pulse <= 12'd0;
            if (sw_write_strobe && (r_state != c_ST_IDLE)) begin
                r_err_ovr <= 1'b1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (sw_write_strobe) begin
                        r_body <= sw_write32_0[23:0];
                        r_sel  <= w_dev_idx;
                        r_op   <= w_op;
                        if ((w_dev == 4'd0) && (w_op == 4'hA)) begin
                            r_err_dev <= 1'b0;
                            r_err_op  <= 1'b0;
                            r_err_to  <= 1'b0;
                            r_err_ovr <= 1'b0;
                            r_done    <= 1'b0;
                        end else if (!w_dev_ok || !w_op_ok) begin
                            r_err_dev <= r_err_dev | ~w_dev_ok;
                            r_err_op  <= r_err_op | ~w_op_ok;
                            r_done    <= 1'b1;
                        end else if (w_op == 4'h0) begin
                            r_done  <= 1'b1;
                            r_count <= r_count + 16'd1;
                        end else begin
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= c_ST_ISSUE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_en    <= w_sel_onehot;
                    r_pulse <= 12'd1 << r_op;
                    r_cnt   <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // a done on the limit cycle takes priority over the abort
                    if (w_sel_done) begin
                        r_state <= c_ST_CAPTURE;
                    end else if (w_timeout) begin
                        r_err_to <= 1'b1;
                        r_rd0    <= 32'd0;
                        r_rd1    <= 32'd0;
                        r_busy   <= 1'b0;
                        r_en     <= '0;
                        r_count  <= r_count + 16'd1;
                        r_state  <= c_ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                c_ST_CAPTURE: begin
                    r_rd0   <= w_sel_data;
                    r_rd1   <= w_sel_stat;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_count <= r_count + 16'd1;
                    r_en    <= '0;
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign sw_read32_0      = r_rd0;
    assign sw_read32_1      = r_rd1;
    assign sw_read32_2      = {r_busy, r_done, r_err_dev, r_err_op, r_err_to, r_err_ovr,
                               10'd0, r_count};
    assign fw_dev_id_enable = r_en;
    assign fw_op_pulse      = r_pulse;
    assign sw_write24_0     = r_body;

endmodule
`default_nettype wire

// File: tb/tb_com_sw_to_fw_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_com_sw_to_fw_seq
//  Description : Directed plus randomized bench for com_sw_to_fw_seq with a
//                rule-level reference model of the bridge status.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_com_sw_to_fw_seq;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4 x one-hot instance
    logic         a_stb;
    logic [31:0]  a_word;
    logic [31:0]  a_rd0, a_rd1, a_rd2;
    logic [3:0]   a_en;
    logic [11:0]  a_pulse;
    logic [23:0]  a_body;
    logic [3:0]   a_done;
    logic [31:0]  a_data [4];
    logic [31:0]  a_stat [4];
    logic [127:0] a_data_flat, a_stat_flat;
    assign a_data_flat = {a_data[3], a_data[2], a_data[1], a_data[0]};
    assign a_stat_flat = {a_stat[3], a_stat[2], a_stat[1], a_stat[0]};

    // 8 x binary instance
    logic         b_stb;
    logic [31:0]  b_word;
    logic [31:0]  b_rd0, b_rd1, b_rd2;
    logic [7:0]   b_en;
    logic [11:0]  b_pulse;
    logic [23:0]  b_body;
    logic [7:0]   b_done;
    logic [255:0] b_data_flat, b_stat_flat;

    com_sw_to_fw_seq #(.NUM_FW(4), .DEV_ID_ONEHOT(1), .TIMEOUT_CYCLES(T)) dut_a (
        .fw_axi_clk(clk), .fw_rst_n(rst_n), .sw_write_strobe(a_stb), .sw_write32_0(a_word),
        .sw_read32_0(a_rd0), .sw_read32_1(a_rd1), .sw_read32_2(a_rd2),
        .fw_dev_id_enable(a_en), .fw_op_pulse(a_pulse), .sw_write24_0(a_body),
        .fw_op_done(a_done), .fw_read_data32(a_data_flat), .fw_read_status32(a_stat_flat));

    com_sw_to_fw_seq #(.NUM_FW(8), .DEV_ID_ONEHOT(0), .TIMEOUT_CYCLES(T)) dut_b (
        .fw_axi_clk(clk), .fw_rst_n(rst_n), .sw_write_strobe(b_stb), .sw_write32_0(b_word),
        .sw_read32_0(b_rd0), .sw_read32_1(b_rd1), .sw_read32_2(b_rd2),
        .fw_dev_id_enable(b_en), .fw_op_pulse(b_pulse), .sw_write24_0(b_body),
        .fw_op_done(b_done), .fw_read_data32(b_data_flat), .fw_read_status32(b_stat_flat));

    int checks = 0;
    int errors = 0;

    // reference model of the bridge's SW-visible state
    bit          m_dev, m_op, m_to, m_ovr, m_done;
    logic [15:0] m_count;
    logic [31:0] m_rd0, m_rd1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_st(input bit busy);
        return {busy, m_done, m_dev, m_op, m_to, m_ovr, 10'd0, m_count};
    endfunction

    function automatic int dev_index(input logic [3:0] dev, input bit onehot, input int nfw);
        if (onehot) begin
            for (int i = 0; i < nfw && i < 4; i++)
                if (dev == 4'(1 << i)) return i;
            return -1;
        end
        if (dev >= 4'd1 && int'(dev) <= nfw) return int'(dev) - 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_dev = 0; m_op = 0; m_to = 0; m_ovr = 0; m_done = 0;
        m_count = 16'd0; m_rd0 = 32'd0; m_rd1 = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_strobe(input logic [31:0] w);
        a_word = w;
        a_stb  = 1'b1;
        tick();
        a_stb  = 1'b0;
    endtask

    // One full command on instance A, checked against the model
    task automatic exec_a(input logic [31:0] w, input int delay, input bit timeout,
                          input logic [31:0] data, input logic [31:0] stat, input logic [3:0] noise);
        logic [3:0] dev, op;
        int idx;
        dev = w[31:28];
        op  = w[27:24];
        idx = dev_index(dev, 1'b1, 4);
        a_strobe(w);
        check("body", {8'd0, a_body}, {8'd0, w[23:0]});
        if (dev == 4'd0 && op == 4'hA) begin
            m_dev = 0; m_op = 0; m_to = 0; m_ovr = 0; m_done = 0;
        end else if (idx < 0 || op > 4'hB) begin
            if (idx < 0) m_dev = 1;
            if (op > 4'hB) m_op = 1;
            m_done = 1;
        end else if (op == 4'h0) begin
            m_done = 1;
            m_count++;
        end else begin
            m_done = 0;
            check("busy_status", a_rd2, exp_st(1'b1));
            check("no_early_pulse", {20'd0, a_pulse}, 32'd0);
            tick();
            check("op_pulse", {20'd0, a_pulse}, 32'd1 << op);
            check("enable", {28'd0, a_en}, 32'd1 << idx);
            tick();
            check("pulse_1cyc", {20'd0, a_pulse}, 32'd0);
            if (timeout) begin
                repeat (T - 2) tick();
                check("no_early_timeout", {31'd0, a_rd2[27]}, 32'd0);
                tick();
                m_to = 1; m_rd0 = 32'd0; m_rd1 = 32'd0; m_count++;
            end else begin
                a_done = noise & ~(4'd1 << idx);
                repeat (delay) tick();
                a_data[idx] = data;
                a_stat[idx] = stat;
                a_done = 4'd1 << idx;
                tick();
                a_done = 4'd0;
                check("enable_held", {28'd0, a_en}, 32'd1 << idx);
                tick();
                m_rd0 = data; m_rd1 = stat; m_done = 1; m_count++;
            end
        end
        if (!(idx >= 0 && op <= 4'hB && op != 4'h0)) begin
            tick();
            check("no_pulse", {20'd0, a_pulse}, 32'd0);
        end
        check("read0", a_rd0, m_rd0);
        check("read1", a_rd1, m_rd1);
        check("status", a_rd2, exp_st(1'b0));
        check("enable_idle", {28'd0, a_en}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  d, vdev;
        int          cat;
        bit          to;

        a_stb = 0; a_word = 0; a_done = 0;
        b_stb = 0; b_word = 0; b_done = 0;
        b_data_flat = '0; b_stat_flat = '0;
        for (int i = 0; i < 4; i++) begin a_data[i] = 32'd0; a_stat[i] = 32'd0; end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_read0", a_rd0, 32'd0);
        check("rst_read1", a_rd1, 32'd0);
        check("rst_status", a_rd2, 32'd0);
        check("rst_enable", {28'd0, a_en}, 32'd0);
        check("rst_pulse", {20'd0, a_pulse}, 32'd0);
        check("rst_body", {8'd0, a_body}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Binary-mode instance, 8 FW blocks
        b_data_flat[6*32 +: 32] = 32'h7777_0006;
        b_stat_flat[6*32 +: 32] = 32'h0000_0066;
        b_word = 32'h7800_0000; b_stb = 1; tick(); b_stb = 0;
        tick();
        check("b_enable", {24'd0, b_en}, 32'h40);
        check("b_pulse", {20'd0, b_pulse}, 32'h100);
        tick();
        check("b_pulse_1cyc", {20'd0, b_pulse}, 32'd0);
        b_done = 8'h40; tick(); b_done = 8'h00; tick();
        check("b_read0", b_rd0, 32'h7777_0006);
        check("b_read1", b_rd1, 32'h0000_0066);
        check("b_status", b_rd2, 32'h4000_0001);
        b_word = 32'h9800_0000; b_stb = 1; tick(); b_stb = 0; tick();
        check("b_err_dev", b_rd2, 32'h6000_0001);
        check("b_no_pulse", {20'd0, b_pulse}, 32'd0);

        // Basic transaction to FW1
        exec_a(32'h2300_00AB, 2, 0, 32'h1234_5678, 32'h0000_00C3, 4'd0);
        check("t1_count", {16'd0, a_rd2[15:0]}, 32'd1);
        check("t1_done", {31'd0, a_rd2[30]}, 32'd1);

        // Invalid dev then clear
        exec_a(32'h3200_0000, 0, 0, 0, 0, 4'd0);
        check("t2_err_dev", {31'd0, a_rd2[29]}, 32'd1);
        exec_a(32'h0A00_0000, 0, 0, 0, 0, 4'd0);
        check("t2_cleared", {31'd0, a_rd2[29]}, 32'd0);

        // NOOP and invalid op
        exec_a(32'h4000_0000, 0, 0, 0, 0, 4'd0);
        exec_a(32'h1C00_0000, 0, 0, 0, 0, 4'd0);
        exec_a(32'h0A00_0000, 0, 0, 0, 0, 4'd0);

        // Timeout, then done on the very last WAIT cycle
        exec_a(32'h1B00_0001, 0, 1, 0, 0, 4'd0);
        check("t3_err_timeout", {31'd0, a_rd2[27]}, 32'd1);
        check("t3_read0", a_rd0, 32'd0);
        exec_a(32'h0A00_0000, 0, 0, 0, 0, 4'd0);
        exec_a(32'h2700_0000, T - 2, 0, 32'hA5A5_0102, 32'h0000_0011, 4'd0);
        check("tie_no_timeout", {31'd0, a_rd2[27]}, 32'd0);

        // Overrun during WAIT with a foreign done pulse, then strobe in CAPTURE
        a_strobe(32'h1500_0055);
        m_done = 0;
        tick(); tick();
        a_word = 32'h2500_0000; a_stb = 1; a_done = 4'b0100; a_data[2] = 32'hDEAD_BEEF;
        tick();
        a_stb = 0; a_done = 4'd0;
        m_ovr = 1;
        check("t4_overrun_busy", a_rd2, exp_st(1'b1));
        check("t4_enable", {28'd0, a_en}, 32'd1);
        check("t4_body", {8'd0, a_body}, 32'h55);
        repeat (2) tick();
        a_data[0] = 32'hCAFE_0001; a_stat[0] = 32'h0000_0005; a_done = 4'b0001;
        tick();
        a_done = 4'd0; a_word = 32'h1000_0000; a_stb = 1;
        tick();
        a_stb = 0;
        m_rd0 = 32'hCAFE_0001; m_rd1 = 32'h0000_0005; m_done = 1; m_count++;
        check("t4_read0", a_rd0, m_rd0);
        check("t4_status", a_rd2, exp_st(1'b0));
        tick();
        check("t4_capture_drop", a_rd2, exp_st(1'b0));
        exec_a(32'h0A00_0000, 0, 0, 0, 0, 4'd0);

        // Randomized commands
        for (int n = 0; n < 60; n++) begin
            cat  = $urandom_range(0, 9);
            vdev = 4'(1 << $urandom_range(0, 3));
            to   = 0;
            case (cat)
                0: w = {4'h0, 4'hA, 24'($urandom)};
                1: w = {vdev, 4'($urandom_range(12, 15)), 24'($urandom)};
                2: begin
                    d = 4'($urandom_range(0, 15));
                    while (d == 4'd1 || d == 4'd2 || d == 4'd4 || d == 4'd8) d = 4'($urandom_range(0, 15));
                    w = {d, 4'($urandom_range(1, 9)), 24'($urandom)};
                end
                3: w = {vdev, 4'h0, 24'($urandom)};
                default: begin
                    w  = {vdev, 4'($urandom_range(1, 11)), 24'($urandom)};
                    to = (cat == 4) && ($urandom_range(0, 2) == 0);
                end
            endcase
            exec_a(w, $urandom_range(0, 5), to, $urandom, $urandom, 4'($urandom));
        end

        // Reset while waiting on FW2
        a_data[2] = 32'h0BAD_0002;
        exec_a(32'h4100_0000, 0, 0, 32'h0BAD_0002, 32'h1, 4'd0);
        a_strobe(32'h4600_0000);
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_read0", a_rd0, 32'd0);
        check("t6_read1", a_rd1, 32'd0);
        check("t6_status", a_rd2, 32'd0);
        check("t6_enable", {28'd0, a_en}, 32'd0);
        check("t6_body", {8'd0, a_body}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        exec_a(32'h2300_00AB, 2, 0, 32'h1234_5678, 32'h0000_00C3, 4'd0);
        check("t6_count", {16'd0, a_rd2[15:0]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
